tra_mon: RTL

TRA_MON -- requirements
Module: tra_mon

---
 rtl/tra_pkg.sv | 41 ++++
 rtl/tra_axis_chk.sv | 85 ++++++++
 rtl/tra_mon.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/tra_pkg.sv
// Shared definitions for the traffic-light safety monitor.
// Latency: none (types, constants and one pure function).
// Backpressure: not applicable.
package tra_pkg;

    // Car light encodings
    localparam logic [1:0] CAR_RED    = 2'b00;
    localparam logic [1:0] CAR_GREEN  = 2'b01;
    localparam logic [1:0] CAR_YELLOW = 2'b10;

    // Pedestrian light encodings
    localparam logic [1:0] HMN_DONT_WALK = 2'b00;
    localparam logic [1:0] HMN_WALK      = 2'b01;
    localparam logic [1:0] HMN_FLASH     = 2'b10;

    // Shared by both light types
    localparam logic [1:0] LIGHT_INV = 2'b11;

    // Fault codes; a lower value wins when several fire together
    localparam logic [2:0] FC_NONE         = 3'd0;
    localparam logic [2:0] FC_CONFLICT     = 3'd1;
    localparam logic [2:0] FC_TRANSITION   = 3'd2;
    localparam logic [2:0] FC_INVALID      = 3'd3;
    localparam logic [2:0] FC_YELLOW_LEN   = 3'd4;
    localparam logic [2:0] FC_HMN_CONFLICT = 3'd5;
    localparam logic [2:0] FC_RED_TIMEOUT  = 3'd6;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    // The only car changes allowed: RED->GREEN, GREEN->YELLOW, YELLOW->RED
    function automatic logic car_step_legal(input logic [1:0] prev, input logic [1:0] cur);
        return ((prev == CAR_RED)    && (cur == CAR_GREEN))  ||
               ((prev == CAR_GREEN)  && (cur == CAR_YELLOW)) ||
               ((prev == CAR_YELLOW) && (cur == CAR_RED));
    endfunction

endpackage

// File: rtl/tra_axis_chk.sv
// Per-axis sampler and rule checker: samples car/hmn lights, tracks dwell, flags codes 2..6.
// Latency: inputs registered once; check outputs are combinational on the registered samples.
// Backpressure: none; evaluates every cycle.
// Ports: car_i/hmn_i raw lights; car_o current car sample; valid_o no 11 in the current samples;
//        gr2yl_o GREEN->YELLOW seen; viol_o/code_o lowest-code violation on this axis.
module tra_axis_chk
    import tra_pkg::*;
#(
    parameter int YELLOW_LEN = 5,
    parameter int MAX_RED    = 100,
    parameter int CNT_W      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] car_i,
    input  logic [1:0] hmn_i,
    output logic [1:0] car_o,
    output logic       valid_o,
    output logic       gr2yl_o,
    output logic       viol_o,
    output logic [2:0] code_o
);

    logic [1:0]       car_q;
    logic [1:0]       car_prev_q;
    logic [1:0]       hmn_q;
    logic [CNT_W-1:0] dwell_q;
    logic [CNT_W-1:0] dwell_d;
    logic             car_chg;
    logic             c2_trans;
    logic             c3_inv;
    logic             c4_yel;
    logic             c5_hmn;
    logic             c6_red;

    assign car_chg = (car_q != car_prev_q);

    // dwell_q trails the sample by one cycle, so it always holds the run
    // length of car_prev_q. That is exactly the dwell needed on a phase exit.
    always_comb begin
        dwell_d = dwell_q;
        if (car_chg) begin
            dwell_d = CNT_W'(1);
        end else if (dwell_q != {CNT_W{1'b1}}) begin
            dwell_d = dwell_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            car_q      <= CAR_RED;
            car_prev_q <= CAR_RED;
            hmn_q      <= HMN_DONT_WALK;
            dwell_q    <= '0;
        end else begin
            car_prev_q <= car_q;
            car_q      <= car_i;
            hmn_q      <= hmn_i;
            dwell_q    <= dwell_d;
        end
    end

    assign c2_trans = car_chg && !car_step_legal(car_prev_q, car_q);
    assign c3_inv   = (car_q == LIGHT_INV) || (hmn_q == LIGHT_INV);
    assign c4_yel   = (car_prev_q == CAR_YELLOW) && (car_q != CAR_YELLOW) &&
                      (dwell_q != CNT_W'(YELLOW_LEN));
    assign c5_hmn   = ((hmn_q == HMN_WALK) || (hmn_q == HMN_FLASH)) && (car_q != CAR_RED);
    assign c6_red   = (car_prev_q == CAR_RED) && (dwell_q > CNT_W'(MAX_RED));

    always_comb begin
        viol_o = 1'b1;
        code_o = FC_NONE;
        if (c2_trans)    code_o = FC_TRANSITION;
        else if (c3_inv) code_o = FC_INVALID;
        else if (c4_yel) code_o = FC_YELLOW_LEN;
        else if (c5_hmn) code_o = FC_HMN_CONFLICT;
        else if (c6_red) code_o = FC_RED_TIMEOUT;
        else             viol_o = 1'b0;
    end

    assign car_o   = car_q;
    assign valid_o = !c3_inv;
    assign gr2yl_o = (car_prev_q == CAR_GREEN) && (car_q == CAR_YELLOW);

endmodule

// File: rtl/tra_mon.sv
// Traffic-light safety monitor: checks both axes, latches the first fault, counts NS phases.
// Latency: viol_pulse/fault appear on the second rising edge after the offending input.
// Backpressure: none; every cycle is checked.
// Ports: ns/ew_car, ns/ew_hmn lights; clr_fault re-arm; fault/fault_code/fault_axis latched
//        first violation; viol_pulse per-cycle detect; armed in RUN; ns_phase_cnt GREEN->YELLOW count.
module tra_mon
    import tra_pkg::*;
#(
    parameter int YELLOW_LEN = 5,
    parameter int MAX_RED    = 100,
    parameter int CNT_W      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] ns_car,
    input  logic [1:0] ew_car,
    input  logic [1:0] ns_hmn,
    input  logic [1:0] ew_hmn,
    input  logic       clr_fault,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       fault_axis,
    output logic       viol_pulse,
    output logic       armed,
    output logic [7:0] ns_phase_cnt
);

    logic [1:0] ns_car_s, ew_car_s;
    logic       ns_valid, ew_valid;
    logic       ns_gr2yl, ew_gr2yl_unused;
    logic       ns_viol, ew_viol;
    logic [2:0] ns_code, ew_code;

    tra_axis_chk #(.YELLOW_LEN(YELLOW_LEN), .MAX_RED(MAX_RED), .CNT_W(CNT_W)) u_ns (
        .clk     (clk),
        .rst_n   (rst_n),
        .car_i   (ns_car),
        .hmn_i   (ns_hmn),
        .car_o   (ns_car_s),
        .valid_o (ns_valid),
        .gr2yl_o (ns_gr2yl),
        .viol_o  (ns_viol),
        .code_o  (ns_code)
    );

    tra_axis_chk #(.YELLOW_LEN(YELLOW_LEN), .MAX_RED(MAX_RED), .CNT_W(CNT_W)) u_ew (
        .clk     (clk),
        .rst_n   (rst_n),
        .car_i   (ew_car),
        .hmn_i   (ew_hmn),
        .car_o   (ew_car_s),
        .valid_o (ew_valid),
        .gr2yl_o (ew_gr2yl_unused),
        .viol_o  (ew_viol),
        .code_o  (ew_code)
    );

    state_t     state_q;
    logic       fault_q, fault_axis_q, viol_pulse_q, armed_q;
    logic [2:0] fault_code_q;
    logic [7:0] ns_phase_cnt_q;
    logic       conflict, arm_ok, viol_det;
    logic       sel_vld, sel_axis;
    logic [2:0] sel_code;

    assign conflict = (ns_car_s != CAR_RED) && (ew_car_s != CAR_RED);
    assign arm_ok   = ns_valid && ew_valid && !conflict;

    // Conflict is code 1, below anything an axis can report; otherwise the
    // lower axis code wins and NS takes ties.
    always_comb begin
        sel_vld  = 1'b0;
        sel_code = FC_NONE;
        sel_axis = 1'b0;
        if (conflict) begin
            sel_vld  = 1'b1;
            sel_code = FC_CONFLICT;
        end else if (ns_viol && (!ew_viol || (ns_code <= ew_code))) begin
            sel_vld  = 1'b1;
            sel_code = ns_code;
        end else if (ew_viol) begin
            sel_vld  = 1'b1;
            sel_code = ew_code;
            sel_axis = 1'b1;
        end
    end

    assign viol_det = sel_vld && (state_q != ST_INIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_INIT;
            fault_q        <= 1'b0;
            fault_code_q   <= FC_NONE;
            fault_axis_q   <= 1'b0;
            viol_pulse_q   <= 1'b0;
            armed_q        <= 1'b0;
            ns_phase_cnt_q <= '0;
        end else begin
            viol_pulse_q <= viol_det;
            if ((state_q == ST_RUN) && ns_gr2yl) begin
                ns_phase_cnt_q <= ns_phase_cnt_q + 8'd1;
            end
            // clr_fault overrides whatever the checks saw this cycle
            if (clr_fault) begin
                state_q      <= ST_INIT;
                fault_q      <= 1'b0;
                fault_code_q <= FC_NONE;
                fault_axis_q <= 1'b0;
                armed_q      <= 1'b0;
            end else begin
                case (state_q)
                    ST_INIT: begin
                        if (arm_ok) begin
                            state_q <= ST_RUN;
                            armed_q <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (viol_det) begin
                            state_q      <= ST_FAULT;
                            armed_q      <= 1'b0;
                            fault_q      <= 1'b1;
                            fault_code_q <= sel_code;
                            fault_axis_q <= sel_axis;
                        end
                    end
                    ST_FAULT: begin
                        // first fault stays latched until clr_fault
                    end
                    default: begin
                        state_q <= ST_INIT;
                        armed_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign fault        = fault_q;
    assign fault_code   = fault_code_q;
    assign fault_axis   = fault_axis_q;
    assign viol_pulse   = viol_pulse_q;
    assign armed        = armed_q;
    assign ns_phase_cnt = ns_phase_cnt_q;

endmodule
